// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues single-outstanding
// requests to instruction memory and buffers returned words in a 2-entry
// prefetch queue that feeds the IF/ID pipeline register.
module if_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifid_stall,
    input  logic        branch_valid,
    input  logic [15:0] branch_target,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic [15:0] inst_curr,
    output logic [15:0] pc_added,
    output logic        fetch_valid
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [0:0]  state;
    logic        outstanding;
    logic        kill;
    logic [15:0] fetch_pc;
    logic [15:0] last_pc_added;

    logic [15:0] q0_inst;
    logic [15:0] q0_pc;
    logic [15:0] q1_inst;
    logic [15:0] q1_pc;
    logic [1:0]  count;

    logic        stalled;
    logic        ack_live;
    logic        push;
    logic        pop;
    logic [2:0]  occ_next;

    // Handshake decode, queue occupancy look-ahead and output muxing
    always_comb begin
        outstanding = (state == WAIT);
        // Only a definite 1 holds the stage; X/Z on the stall line lets it advance
        stalled     = (ifid_stall === 1'b1);
        fetch_valid = (count != 2'd0);
        ack_live    = imem_ack & outstanding;
        push        = ack_live & ~kill & ~branch_valid;
        pop         = fetch_valid & ~stalled & ~branch_valid;
        occ_next    = {1'b0, count} + {2'b00, push} - {2'b00, pop};
        imem_req    = ~rst & ~branch_valid & (~outstanding | imem_ack) & (occ_next < 3'd2);
        imem_addr   = fetch_pc;
        inst_curr   = fetch_valid ? q0_inst : NOP_INST;
        pc_added    = fetch_valid ? q0_pc   : last_pc_added;
    end

    // Request FSM, fetch PC and stale-response kill flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            kill     <= 1'b0;
            fetch_pc <= RESET_PC;
        end else if (branch_valid) begin
            fetch_pc <= branch_target;
            // A request still in flight must have its eventual response dropped
            kill     <= outstanding & ~imem_ack;
            state    <= (outstanding & ~imem_ack) ? WAIT : IDLE;
        end else begin
            if (imem_req) begin
                state    <= WAIT;
                fetch_pc <= fetch_pc + 16'd1;
            end else if (ack_live) begin
                state <= IDLE;
            end
            if (ack_live) begin
                kill <= 1'b0;
            end
        end
    end

    // Prefetch queue: head in q0, push/pop may coincide.
    // While a request is in flight fetch_pc already holds its address + 1,
    // so that value is the entry's pc_added without a separate address register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count         <= 2'd0;
            q0_inst       <= '0;
            q0_pc         <= '0;
            q1_inst       <= '0;
            q1_pc         <= '0;
            last_pc_added <= '0;
        end else if (branch_valid) begin
            count <= 2'd0;
        end else begin
            if (pop) begin
                last_pc_added <= q0_pc;
            end
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        q0_inst <= imem_rdata;
                        q0_pc   <= fetch_pc;
                    end else begin
                        q1_inst <= imem_rdata;
                        q1_pc   <= fetch_pc;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    q0_inst <= q1_inst;
                    q0_pc   <= q1_pc;
                    count   <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        q0_inst <= imem_rdata;
                        q0_pc   <= fetch_pc;
                    end else begin
                        q0_inst <= q1_inst;
                        q0_pc   <= q1_pc;
                        q1_inst <= imem_rdata;
                        q1_pc   <= fetch_pc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a default-parameter instance with a
// variable-latency memory model, plus a wrap-around instance at 16'hFFFE.
module tb_if_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        stall;
    logic        bv;
    logic [15:0] bt;

    logic        req;
    logic [15:0] addr;
    logic        ack;
    logic [15:0] rdata;
    logic [15:0] inst;
    logic [15:0] pca;
    logic        fv;

    logic        req_w;
    logic [15:0] addr_w;
    logic        ack_w;
    logic [15:0] rdata_w;
    logic [15:0] inst_w;
    logic [15:0] pca_w;
    logic        fv_w;

    int vectors = 0;
    int miscompares = 0;

    int          lat;
    logic        mem_en;
    logic        t_ack;
    logic [15:0] t_rdata;
    logic        m_ack;
    logic [15:0] m_rdata;
    int          rem;
    logic [15:0] paddr;

    assign ack   = mem_en ? m_ack   : t_ack;
    assign rdata = mem_en ? m_rdata : t_rdata;

    if_fetch #(.RESET_PC(16'h0000), .NOP_INST(16'h0000)) dut (
        .clk(clk), .rst(rst), .ifid_stall(stall), .branch_valid(bv), .branch_target(bt),
        .imem_req(req), .imem_addr(addr), .imem_ack(ack), .imem_rdata(rdata),
        .inst_curr(inst), .pc_added(pca), .fetch_valid(fv)
    );

    if_fetch #(.RESET_PC(16'hFFFE), .NOP_INST(16'hBEEF)) dut_w (
        .clk(clk), .rst(rst), .ifid_stall(stall), .branch_valid(bv), .branch_target(bt),
        .imem_req(req_w), .imem_addr(addr_w), .imem_ack(ack_w), .imem_rdata(rdata_w),
        .inst_curr(inst_w), .pc_added(pca_w), .fetch_valid(fv_w)
    );

    // Memory for dut: answers addr^A5A5 'lat' cycles after the accepting edge
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ack   <= 1'b0;
            m_rdata <= '0;
            rem     <= 0;
            paddr   <= '0;
        end else begin
            m_ack <= 1'b0;
            if (req) begin
                if (lat == 1) begin
                    m_ack   <= 1'b1;
                    m_rdata <= addr ^ 16'hA5A5;
                end else begin
                    rem   <= lat - 1;
                    paddr <= addr;
                end
            end else if (rem > 0) begin
                rem <= rem - 1;
                if (rem == 1) begin
                    m_ack   <= 1'b1;
                    m_rdata <= paddr ^ 16'hA5A5;
                end
            end
        end
    end

    // Memory for dut_w: fixed 1-cycle latency
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_w   <= 1'b0;
            rdata_w <= '0;
        end else begin
            ack_w   <= req_w;
            rdata_w <= addr_w ^ 16'hA5A5;
        end
    end

    // Leaves the bench 2 time units into cycle 0 after reset release
    task automatic do_reset(input int l);
        rst = 1'b1; stall = 1'b0; bv = 1'b0; bt = '0;
        lat = l; mem_en = 1'b1; t_ack = 1'b0; t_rdata = '0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        do_reset(1);
        vectors++; if (req !== 1'b1) begin miscompares++; $display("FAIL reset_req got=%b exp=1", req); end
        vectors++; if (addr !== 16'h0000) begin miscompares++; $display("FAIL reset_addr got=%h exp=0000", addr); end
        vectors++; if (fv !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b exp=0", fv); end
        vectors++; if (inst !== 16'h0000) begin miscompares++; $display("FAIL reset_inst got=%h exp=0000", inst); end
        vectors++; if (pca !== 16'h0000) begin miscompares++; $display("FAIL reset_pc got=%h exp=0000", pca); end
        vectors++; if (inst_w !== 16'hBEEF) begin miscompares++; $display("FAIL reset_nop_w got=%h exp=beef", inst_w); end
        vectors++; if (addr_w !== 16'hFFFE) begin miscompares++; $display("FAIL reset_addr_w got=%h exp=fffe", addr_w); end
    endtask

    task automatic test_stream;
        logic [15:0] e_inst, e_pc;
        do_reset(1);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin @(posedge clk); #2; end
            vectors++; if (req !== 1'b1 || addr !== 16'(k)) begin
                miscompares++; $display("FAIL stream_req cyc=%0d got=%b/%h exp=1/%h", k, req, addr, 16'(k)); end
            if (k >= 2) begin
                e_inst = 16'(k - 2) ^ 16'hA5A5;
                e_pc   = 16'(k - 1);
                vectors++; if (fv !== 1'b1 || inst !== e_inst || pca !== e_pc) begin
                    miscompares++; $display("FAIL stream_out cyc=%0d got=%b/%h/%h exp=1/%h/%h", k, fv, inst, pca, e_inst, e_pc); end
            end
        end
    endtask

    task automatic test_stall;
        logic [15:0] e_inst, e_pc;
        do_reset(1);
        for (int k = 0; k < 13; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            stall = (k >= 3 && k <= 7);
            #1;
            if (k >= 3 && k <= 7) begin
                vectors++; if (req !== 1'b0) begin miscompares++; $display("FAIL stall_req cyc=%0d got=%b exp=0", k, req); end
                vectors++; if (fv !== 1'b1 || inst !== 16'hA5A4 || pca !== 16'h0002) begin
                    miscompares++; $display("FAIL stall_hold cyc=%0d got=%b/%h/%h exp=1/a5a4/0002", k, fv, inst, pca); end
            end
            if (k == 8) begin
                vectors++; if (req !== 1'b1 || addr !== 16'h0003) begin
                    miscompares++; $display("FAIL stall_resume got=%b/%h exp=1/0003", req, addr); end
            end
            if (k >= 8) begin
                e_pc   = 16'(k - 6);
                e_inst = 16'(k - 7) ^ 16'hA5A5;
                vectors++; if (fv !== 1'b1 || inst !== e_inst || pca !== e_pc) begin
                    miscompares++; $display("FAIL stall_drain cyc=%0d got=%b/%h/%h exp=1/%h/%h", k, fv, inst, pca, e_inst, e_pc); end
            end
        end
    endtask

    task automatic test_redirect_latency;
        do_reset(3);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            bv = (k == 1);
            bt = (k == 1) ? 16'h0040 : 16'h0000;
            #1;
            if (k == 1 || k == 2) begin
                vectors++; if (req !== 1'b0) begin miscompares++; $display("FAIL redir_noreq cyc=%0d got=%b exp=0", k, req); end
            end
            if (k == 3) begin
                vectors++; if (req !== 1'b1 || addr !== 16'h0040) begin
                    miscompares++; $display("FAIL redir_target got=%b/%h exp=1/0040", req, addr); end
            end
            if (k >= 2 && k <= 6) begin
                vectors++; if (fv !== 1'b0 || inst !== 16'h0000 || pca !== 16'h0000) begin
                    miscompares++; $display("FAIL redir_bubble cyc=%0d got=%b/%h/%h exp=0/0000/0000", k, fv, inst, pca); end
            end
            if (k == 7) begin
                vectors++; if (fv !== 1'b1 || inst !== 16'hA5E5 || pca !== 16'h0041) begin
                    miscompares++; $display("FAIL redir_first got=%b/%h/%h exp=1/a5e5/0041", fv, inst, pca); end
            end
        end
        bv = 1'b0; bt = '0;
    endtask

    task automatic test_redirect_ack_stall;
        do_reset(1);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            bv    = (k == 2);
            stall = (k == 2);
            bt    = (k == 2) ? 16'h0080 : 16'h0000;
            #1;
            if (k == 2) begin
                vectors++; if (req !== 1'b0 || fv !== 1'b1 || inst !== 16'hA5A5) begin
                    miscompares++; $display("FAIL rack_cycle got=%b/%b/%h exp=0/1/a5a5", req, fv, inst); end
            end
            if (k == 3) begin
                vectors++; if (fv !== 1'b0 || inst !== 16'h0000 || pca !== 16'h0000) begin
                    miscompares++; $display("FAIL rack_empty got=%b/%h/%h exp=0/0000/0000", fv, inst, pca); end
                vectors++; if (req !== 1'b1 || addr !== 16'h0080) begin
                    miscompares++; $display("FAIL rack_req got=%b/%h exp=1/0080", req, addr); end
            end
            if (k == 4) begin
                vectors++; if (fv !== 1'b0) begin miscompares++; $display("FAIL rack_wait got=%b exp=0", fv); end
            end
            if (k == 5) begin
                vectors++; if (fv !== 1'b1 || inst !== 16'hA525 || pca !== 16'h0081) begin
                    miscompares++; $display("FAIL rack_first got=%b/%h/%h exp=1/a525/0081", fv, inst, pca); end
            end
        end
        bv = 1'b0; stall = 1'b0; bt = '0;
    endtask

    task automatic test_wrap;
        logic [15:0] base, e_addr, e_pc, e_inst;
        base = 16'hFFFE;
        do_reset(1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin @(posedge clk); #2; end
            e_addr = base + 16'(k);
            if (k <= 2) begin
                vectors++; if (req_w !== 1'b1 || addr_w !== e_addr) begin
                    miscompares++; $display("FAIL wrap_addr cyc=%0d got=%b/%h exp=1/%h", k, req_w, addr_w, e_addr); end
            end
            if (k >= 2) begin
                e_pc   = base + 16'(k - 1);
                e_inst = (base + 16'(k - 2)) ^ 16'hA5A5;
                vectors++; if (fv_w !== 1'b1 || inst_w !== e_inst || pca_w !== e_pc) begin
                    miscompares++; $display("FAIL wrap_out cyc=%0d got=%b/%h/%h exp=1/%h/%h", k, fv_w, inst_w, pca_w, e_inst, e_pc); end
            end
        end
    endtask

    task automatic test_reset_midop;
        do_reset(1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            stall = (k >= 3);
            #1;
        end
        vectors++; if (fv !== 1'b1 || inst !== 16'hA5A4 || pca !== 16'h0002) begin
            miscompares++; $display("FAIL midrst_pre got=%b/%h/%h exp=1/a5a4/0002", fv, inst, pca); end
        rst = 1'b1;
        #1;
        vectors++; if (fv !== 1'b0 || inst !== 16'h0000 || pca !== 16'h0000) begin
            miscompares++; $display("FAIL midrst_async got=%b/%h/%h exp=0/0000/0000", fv, inst, pca); end
        @(posedge clk); #1;
        stall = 1'b0; mem_en = 1'b0; t_ack = 1'b1; t_rdata = 16'h1234; rst = 1'b0;
        #1;
        vectors++; if (req !== 1'b1 || addr !== 16'h0000) begin
            miscompares++; $display("FAIL midrst_req got=%b/%h exp=1/0000", req, addr); end
        @(posedge clk); #1;
        t_ack = 1'b0;
        #1;
        vectors++; if (fv !== 1'b0 || req !== 1'b0 || addr !== 16'h0001) begin
            miscompares++; $display("FAIL midrst_spurious got=%b/%b/%h exp=0/0/0001", fv, req, addr); end
        @(posedge clk); #2;
        vectors++; if (fv !== 1'b0) begin miscompares++; $display("FAIL midrst_late got=%b exp=0", fv); end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; bv = 1'b0; bt = '0;
        lat = 1; mem_en = 1'b1; t_ack = 1'b0; t_rdata = '0;
        test_reset;
        test_stream;
        test_stall;
        test_redirect_latency;
        test_redirect_ack_stall;
        test_wrap;
        test_reset_midop;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
